plane_draw_scheduler: RTL
=========================

// Module: plane_draw_scheduler
// PURPOSE
//  Sequences the per-frame redraw of NUM_PLANES falling-plane sprites into the VGA pixel writer.
//  On each frame_tick: erases every sprite at its last-drawn position, pulses move_en once so the
//  y-coordinate counters advance, then redraws every visible sprite at its new position.
//  Sits between the coordinate/visibility registers and the VGA adapter write port.
// PARAMETERS
//  NUM_PLANES   10      number of plane slots
//  COORD_W      8       width of each x/y coordinate and of pix_x/pix_y
//  SPR_W        4       sprite width in pixels
//  SPR_H        4       sprite height in pixels
//  COLOR_W      3       pixel colour width
//  PLANE_COLOR  3'b111  draw colour
//  BG_COLOR     3'b000  erase colour
// PORTS
//  clk          in   1                    system clock, rising edge
//  reset        in   1                    asynchronous, active-high
//  frame_tick   in   1                    one-cycle pulse: start a redraw frame
//  vis          in   NUM_PLANES           slot i visible when vis[i]=1
//  x_in         in   NUM_PLANES*COORD_W   slot i x at [i*COORD_W +: COORD_W]
//  y_in         in   NUM_PLANES*COORD_W   slot i y, same packing
//  pix_ready    in   1                    writer accepts pixel this cycle
//  pix_x        out  COORD_W              pixel x
//  pix_y        out  COORD_W              pixel y
//  pix_colour   out  COLOR_W              pixel colour
//  plot         out  1                    pixel valid
//  move_en      out  1                    one-cycle pulse: advance y counters
//  busy         out  1                    high in every state except IDLE
//  frame_done   out  1                    one-cycle pulse: frame redraw complete
//  frame_overrun out 1                    one-cycle pulse: frame_tick arrived while busy
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, slot index 0, shadow vis/x/y cleared to 0.
//  - States: IDLE, ERASE_SCAN, ERASE_PIX, MOVE, SETTLE, DRAW_SCAN, DRAW_PIX, DONE.
//  - IDLE: frame_tick=1 -> ERASE_SCAN next cycle, slot i=0.
//  - ERASE_SCAN: shadow_vis[i]=1 -> ERASE_PIX (ox=oy=0); else i++; after i=NUM_PLANES-1 -> MOVE.
//  - ERASE_PIX: plot=1, pix=(shadow_x[i]+ox, shadow_y[i]+oy), colour BG_COLOR.
//  - DRAW_SCAN: samples vis[i], x_in/y_in slot i into shadow regs; vis[i]=1 -> DRAW_PIX; else i++.
//    After last slot -> DONE.
//  - DRAW_PIX: as ERASE_PIX, using the freshly latched shadow coords, colour PLANE_COLOR.
//  - Pixel order: raster within sprite, ox fastest; ox wraps at SPR_W-1 with oy++.
//    Offset advances only on a cycle with plot=1 and pix_ready=1.
//    pix_ready=0 holds pix_x/pix_y/pix_colour/plot stable.
//    Last pixel accepted -> i++ and return to SCAN, or next phase on the last slot.
//  - MOVE: move_en=1 for exactly one cycle. SETTLE: one idle cycle so y_in reflects the move.
//  - DONE: frame_done=1 one cycle -> IDLE.
//  - Arithmetic: base+offset is modulo 2^COORD_W; no clipping.
//  - frame_tick while busy: ignored; frame_overrun pulses in the same cycle.
//    The frame in progress is unaffected.
//  - frame_tick in the DONE cycle counts as busy.
//  - Latency, with pix_ready held 1: frame_done asserts
//    3 + 2*NUM_PLANES + SPR_W*SPR_H*(Vold+Vnew) cycles after the tick edge.
//    Vold = popcount(shadow_vis) at start; Vnew = popcount(vis) sampled during DRAW.
//  - Reset mid-frame: immediate return to reset values; the next frame erases nothing.
//  - Outputs are registered (Moore); plot/move_en/frame_done are never high together.
// STRUCTURE
//  - Shared package plane_pkg: sched_state_t enum, NUM_PLANES/COORD_W/COLOR_W defaults,
//    PLANE_COLOR/BG_COLOR constants.
//  - Sub-module sprite_pixel_counter: ox/oy counter with clear, advance and last_pixel flag.
//  - Top level: FSM, slot index, shadow register file, pixel output registers.
// TESTING
//  - Reset with clk running -> all outputs 0; busy=0; no plot for 50 cycles without a tick.
//  - All vis=0, tick -> move_en at cycle 11, frame_done at cycle 23, plot never high.
//  - vis=1 (slot 0), x0=10, y0=20, tick -> 16 plots colour 7 over x 10..13, y 20..23
//    in raster order; no erase pixels; frame_done at cycle 39.
//  - Next frame with y0 22 after move -> 16 colour-0 plots at y 20..23,
//    then move_en once, then 16 colour-7 plots at y 22..25.
//  - pix_ready toggled 1,0,0,1 during DRAW_PIX -> pixel outputs held during stalls,
//    no pixel skipped or duplicated.
//  - x0=254 -> pix_x sequence 254,255,0,1.
//  - tick while busy -> frame_overrun one cycle, frame completes unchanged.
//  - reset asserted mid-DRAW_PIX -> outputs 0 immediately; next frame has no erase pixels.

Source files
------------

// File: rtl/plane_pkg.sv
// Shared types and default sizes for the falling-plane redraw scheduler.
package plane_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_SCAN,
    ERASE_PIX,
    MOVE,
    SETTLE,
    DRAW_SCAN,
    DRAW_PIX,
    DONE
  } sched_state_t;

  localparam int DEF_NUM_PLANES = 10;
  localparam int DEF_COORD_W    = 8;
  localparam int DEF_COLOR_W    = 3;
  localparam int DEF_SPR_W      = 4;
  localparam int DEF_SPR_H      = 4;

  localparam logic [DEF_COLOR_W-1:0] PLANE_COLOR = 3'b111;
  localparam logic [DEF_COLOR_W-1:0] BG_COLOR    = 3'b000;

endpackage

// File: rtl/plane_draw_scheduler_if.sv
// Pixel write port between the redraw scheduler (master) and the VGA pixel writer (slave).
interface plane_draw_scheduler_if #(
  parameter int COORD_W = plane_pkg::DEF_COORD_W,
  parameter int COLOR_W = plane_pkg::DEF_COLOR_W
) ();

  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [COLOR_W-1:0] pix_colour;
  logic               plot;
  logic               pix_ready;

  modport master (
    output pix_x,
    output pix_y,
    output pix_colour,
    output plot,
    input  pix_ready
  );

  modport slave (
    input  pix_x,
    input  pix_y,
    input  pix_colour,
    input  plot,
    output pix_ready
  );

endinterface

// File: rtl/sprite_pixel_counter.sv
// Raster offset walker inside one sprite: ox runs fastest, oy steps when ox wraps.
module sprite_pixel_counter #(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] ox_nxt_o,
  output logic [CNT_W-1:0] oy_nxt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] ox_q;
  logic [CNT_W-1:0] oy_q;
  logic             row_end;
  logic             col_end;

  assign row_end = (ox_q == CNT_W'(SPR_W - 1));
  assign col_end = (oy_q == CNT_W'(SPR_H - 1));
  assign last_o  = row_end & col_end;

  // Next offsets are exposed so the owner can register pixel coordinates in step with the advance.
  assign ox_nxt_o = row_end ? '0 : ox_q + 1'b1;
  assign oy_nxt_o = row_end ? (col_end ? '0 : oy_q + 1'b1) : oy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (clear_i) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (advance_i) begin
      ox_q <= ox_nxt_o;
      oy_q <= oy_nxt_o;
    end
  end

endmodule

// File: rtl/plane_draw_scheduler.sv
// Per-frame erase / move / redraw sequencer feeding sprite pixels to the VGA writer.
module plane_draw_scheduler
  import plane_pkg::*;
#(
  parameter int NUM_PLANES = DEF_NUM_PLANES,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int SPR_W      = DEF_SPR_W,
  parameter int SPR_H      = DEF_SPR_H
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [NUM_PLANES-1:0]         vis,
  input  logic [NUM_PLANES*COORD_W-1:0] x_in,
  input  logic [NUM_PLANES*COORD_W-1:0] y_in,
  plane_draw_scheduler_if.master        pix,
  output logic                          move_en,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_overrun
);

  localparam int IDX_W = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_PLANES - 1);

  sched_state_t          state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_PLANES-1:0] shadow_vis_q;
  logic [COORD_W-1:0]    shadow_x_q [NUM_PLANES];
  logic [COORD_W-1:0]    shadow_y_q [NUM_PLANES];
  logic [COORD_W-1:0]    pix_x_q;
  logic [COORD_W-1:0]    pix_y_q;
  logic [COLOR_W-1:0]    pix_colour_q;
  logic                  plot_q;
  logic                  move_en_q;
  logic                  busy_q;
  logic                  frame_done_q;

  logic [COORD_W-1:0] x_slot [NUM_PLANES];
  logic [COORD_W-1:0] y_slot [NUM_PLANES];

  for (genvar gi = 0; gi < NUM_PLANES; gi++) begin : g_unpack
    assign x_slot[gi] = x_in[gi*COORD_W +: COORD_W];
    assign y_slot[gi] = y_in[gi*COORD_W +: COORD_W];
  end

  logic               accept;
  logic               last_slot;
  logic               cnt_clear;
  logic               last_pix;
  logic [COORD_W-1:0] ox_nxt;
  logic [COORD_W-1:0] oy_nxt;

  assign accept    = plot_q & pix.pix_ready;
  assign last_slot = (idx_q == LAST_SLOT);
  // Offsets restart from the sprite origin every time a slot is scanned.
  assign cnt_clear = (state_q == ERASE_SCAN) || (state_q == DRAW_SCAN);

  sprite_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .CNT_W (COORD_W)
  ) u_pix_cnt (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (cnt_clear),
    .advance_i (accept),
    .ox_nxt_o  (ox_nxt),
    .oy_nxt_o  (oy_nxt),
    .last_o    (last_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shadow_vis_q <= '0;
      for (int k = 0; k < NUM_PLANES; k++) begin
        shadow_x_q[k] <= '0;
        shadow_y_q[k] <= '0;
      end
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= '0;
      plot_q       <= 1'b0;
      move_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q <= ERASE_SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ERASE_SCAN: begin
          if (shadow_vis_q[idx_q]) begin
            state_q      <= ERASE_PIX;
            plot_q       <= 1'b1;
            pix_x_q      <= shadow_x_q[idx_q];
            pix_y_q      <= shadow_y_q[idx_q];
            pix_colour_q <= COLOR_W'(BG_COLOR);
          end else if (last_slot) begin
            state_q   <= MOVE;
            move_en_q <= 1'b1;
            idx_q     <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        // Both pixel phases walk the shadow position; a stalled writer freezes everything.
        ERASE_PIX, DRAW_PIX: begin
          if (accept) begin
            if (!last_pix) begin
              pix_x_q <= shadow_x_q[idx_q] + ox_nxt;
              pix_y_q <= shadow_y_q[idx_q] + oy_nxt;
            end else begin
              plot_q <= 1'b0;
              if (!last_slot) begin
                idx_q   <= idx_q + 1'b1;
                state_q <= (state_q == ERASE_PIX) ? ERASE_SCAN : DRAW_SCAN;
              end else if (state_q == ERASE_PIX) begin
                state_q   <= MOVE;
                move_en_q <= 1'b1;
                idx_q     <= '0;
              end else begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end
            end
          end
        end

        MOVE: begin
          state_q   <= SETTLE;
          move_en_q <= 1'b0;
        end

        SETTLE: begin
          state_q <= DRAW_SCAN;
          idx_q   <= '0;
        end

        // The shadow copy taken here is what the next frame erases.
        DRAW_SCAN: begin
          shadow_vis_q[idx_q] <= vis[idx_q];
          shadow_x_q[idx_q]   <= x_slot[idx_q];
          shadow_y_q[idx_q]   <= y_slot[idx_q];
          if (vis[idx_q]) begin
            state_q      <= DRAW_PIX;
            plot_q       <= 1'b1;
            pix_x_q      <= x_slot[idx_q];
            pix_y_q      <= y_slot[idx_q];
            pix_colour_q <= COLOR_W'(PLANE_COLOR);
          end else if (last_slot) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          state_q      <= IDLE;
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          idx_q        <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix.pix_x      = pix_x_q;
  assign pix.pix_y      = pix_y_q;
  assign pix.pix_colour = pix_colour_q;
  assign pix.plot       = plot_q;
  assign move_en        = move_en_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  // Overrun must flag the offending tick in its own cycle, so it is decoded from the tick directly.
  assign frame_overrun  = frame_tick & busy_q;

endmodule
